pool_result_buffer: RTL and testbench

Downstream stage of `computation_core`. Captures each pooled result (`max_number`, qualified by `flag_store`), applies ReLU and fixed-point requantization back to the 17-bit datapath width, and queues results in a small circular buffer. The buffer drains to the next layer's input loader over a valid/ready stream. It tags the last element of every feature map and reports overflow.

---
 rtl/lenet_pkg.sv | 25 ++
 rtl/pool_result_buffer_if.sv | 36 +++
 rtl/sync_circ_buffer.sv | 90 +++++++++
 rtl/pool_result_buffer.sv | 121 ++++++++++++
 tb/tb_pool_result_buffer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet constants and helpers.
// Contents:
//   BITWIDTH  - datapath width of the accelerator (products are 2*BITWIDTH)
//   POOL1_MAP - pooled elements per feature map after pool1 (14x14)
//   POOL2_MAP - pooled elements per feature map after pool2 (5x5)
//   clog2()   - ceiling log2, usable in constant expressions
package lenet_pkg;

   localparam int BITWIDTH  = 17;
   localparam int POOL1_MAP = 196;
   localparam int POOL2_MAP = 25;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 32'sd0;
      v      = value - 32'sd1;
      while (v > 32'sd0) begin
         result = result + 32'sd1;
         v      = v >>> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pool_result_buffer_if.sv
// Stream bundle between computation_core, pool_result_buffer and the next
// layer's input loader.
// Signals:
//   max_number/flag_store          - pooled value and its one-cycle strobe
//   out_data/out_valid/out_ready   - requantized output stream
//   out_last                       - head entry closes a feature map
//   map_done/overflow/level        - status
// Modports: slave = the buffer, master = the producer/consumer side.
interface pool_result_buffer_if
   import lenet_pkg::*;
#(
   parameter int BITWIDTH = 17,
   parameter int DEPTH    = 16
);

   logic signed [2*BITWIDTH-1:0] max_number;
   logic                         flag_store;
   logic [BITWIDTH-1:0]          out_data;
   logic                         out_valid;
   logic                         out_ready;
   logic                         out_last;
   logic                         map_done;
   logic                         overflow;
   logic [clog2(DEPTH):0]        level;

   modport slave (
      input  max_number, flag_store, out_ready,
      output out_data, out_valid, out_last, map_done, overflow, level
   );

   modport master (
      output max_number, flag_store, out_ready,
      input  out_data, out_valid, out_last, map_done, overflow, level
   );

endinterface

// File: rtl/sync_circ_buffer.sv
// Synchronous circular buffer, DEPTH x WIDTH, with registered head output.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   wr_en, wr_data     - write request (ignored while full)
//   rd_ready           - consumer ready; pops when rd_valid is also high
//   rd_data, rd_valid  - registered head entry and its presence flag
//   full, level        - occupancy status
// Pointers carry one extra wrap bit: equal means empty, MSB-only
// difference means full.
module sync_circ_buffer
   import lenet_pkg::*;
#(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 18,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             valid_q, valid_d;
   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             push;
   logic             pop;

   // Next pointers, status and the head value seen after this edge.
   always_comb begin
      // Full is the registered flag: a same-cycle pop never frees room.
      push     = wr_en && !full_q;
      pop      = valid_q && rd_ready;
      wr_ptr_d = push ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
      level_d  = wr_ptr_d - rd_ptr_d;
      valid_d  = (wr_ptr_d != rd_ptr_d);
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      // Bypass when the new head is the slot being written this edge.
      if (!valid_d) begin
         data_d = {WIDTH{1'b0}};
      end else if (push && (rd_ptr_d == wr_ptr_q)) begin
         data_d = wr_data;
      end else begin
         data_d = mem_q[rd_ptr_d[AW-1:0]];
      end
   end

   // Pointer and registered-output state.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
         level_q  <= {(AW+1){1'b0}};
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         data_q   <= {WIDTH{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         valid_q  <= valid_d;
         full_q   <= full_d;
         data_q   <= data_d;
      end
   end

   // Storage array; contents need no reset because valid gates the output.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data  = data_q;
   assign rd_valid = valid_q;
   assign full     = full_q;
   assign level    = level_q;

endmodule

// File: rtl/pool_result_buffer.sv
// Captures pooled results from computation_core, applies ReLU and
// requantization to BITWIDTH bits, tags the last element of each feature
// map and queues results for the next layer's loader.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - pool_result_buffer_if.slave (capture input, output stream,
//                map_done pulse, sticky overflow, occupancy level)
module pool_result_buffer
   import lenet_pkg::*;
#(
   parameter int BITWIDTH   = lenet_pkg::BITWIDTH,
   parameter int FRAC_SHIFT = 8,
   parameter int DEPTH      = 16,
   parameter int MAP_SIZE   = POOL2_MAP
) (
   input  logic                 clk,
   input  logic                 reset,
   pool_result_buffer_if.slave  bus
);

   localparam int IW = 2 * BITWIDTH;
   localparam int AW = clog2(DEPTH);
   localparam int CW = (clog2(MAP_SIZE) < 1) ? 1 : clog2(MAP_SIZE);
   localparam logic [CW-1:0]       LAST_POS = CW'(MAP_SIZE - 1);
   localparam logic [BITWIDTH-1:0] SAT_MAX  = {1'b0, {(BITWIDTH-1){1'b1}}};

   // ReLU, drop fractional bits, clamp to the largest positive value.
   function automatic logic [BITWIDTH-1:0] requantize(input logic signed [IW-1:0] value);
      logic signed [IW-1:0] shifted;
      logic [BITWIDTH-1:0]  result;
      shifted = value >>> FRAC_SHIFT;
      if (value[IW-1]) begin
         result = {BITWIDTH{1'b0}};
      end else if ($unsigned(shifted) > {{(IW-BITWIDTH){1'b0}}, SAT_MAX}) begin
         result = SAT_MAX;
      end else begin
         result = shifted[BITWIDTH-1:0];
      end
      return result;
   endfunction

   logic                 s1_valid_q, s1_valid_d;
   logic signed [IW-1:0] s1_value_q, s1_value_d;
   logic                 s1_last_q, s1_last_d;
   logic [CW-1:0]        elem_cnt_q, elem_cnt_d;
   logic                 map_done_q, map_done_d;
   logic                 overflow_q, overflow_d;

   logic                 buf_wr_en;
   logic [BITWIDTH:0]    buf_wr_data;
   logic [BITWIDTH:0]    buf_rd_data;
   logic                 buf_rd_valid;
   logic                 buf_full;
   logic [AW:0]          buf_level;

   // Capture stage, positional element counter and overflow tracking.
   always_comb begin
      s1_valid_d = bus.flag_store;
      map_done_d = 1'b0;
      if (bus.flag_store) begin
         s1_value_d = bus.max_number;
         s1_last_d  = (elem_cnt_q == LAST_POS);
         map_done_d = (elem_cnt_q == LAST_POS);
         // Dropped captures still advance the map position.
         if (elem_cnt_q == LAST_POS) begin
            elem_cnt_d = {CW{1'b0}};
         end else begin
            elem_cnt_d = elem_cnt_q + {{(CW-1){1'b0}}, 1'b1};
         end
      end else begin
         s1_value_d = s1_value_q;
         s1_last_d  = s1_last_q;
         elem_cnt_d = elem_cnt_q;
      end
      buf_wr_en   = s1_valid_q && !buf_full;
      buf_wr_data = {s1_last_q, requantize(s1_value_q)};
      overflow_d  = overflow_q || (s1_valid_q && buf_full);
   end

   // Capture and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_value_q <= {IW{1'b0}};
         s1_last_q  <= 1'b0;
         elem_cnt_q <= {CW{1'b0}};
         map_done_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_value_q <= s1_value_d;
         s1_last_q  <= s1_last_d;
         elem_cnt_q <= elem_cnt_d;
         map_done_q <= map_done_d;
         overflow_q <= overflow_d;
      end
   end

   sync_circ_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (BITWIDTH + 1)
   ) u_buf (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (buf_wr_en),
      .wr_data  (buf_wr_data),
      .rd_ready (bus.out_ready),
      .rd_data  (buf_rd_data),
      .rd_valid (buf_rd_valid),
      .full     (buf_full),
      .level    (buf_level)
   );

   assign bus.out_data  = buf_rd_data[BITWIDTH-1:0];
   assign bus.out_last  = buf_rd_data[BITWIDTH];
   assign bus.out_valid = buf_rd_valid;
   assign bus.level     = buf_level;
   assign bus.map_done  = map_done_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_pool_result_buffer.sv
// Directed bench for pool_result_buffer with a scoreboard queue of the
// entries expected inside the buffer.
module tb_pool_result_buffer;
   import lenet_pkg::*;

   localparam int BW    = 17;
   localparam int DEPTH = 16;
   localparam int MAP   = 25;

   logic clk;
   logic reset;

   pool_result_buffer_if #(.BITWIDTH(BW), .DEPTH(DEPTH)) bus ();

   pool_result_buffer #(
      .BITWIDTH   (BW),
      .FRAC_SHIFT (8),
      .DEPTH      (DEPTH),
      .MAP_SIZE   (MAP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          last;
      logic [BW-1:0] data;
   } ent_t;

   ent_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   logic m_s1_v;
   ent_t m_s1_e;
   int   m_elem;
   logic m_md;
   logic m_ovf;
   int   md_seen, pops, last_pops, last_idx;

   function automatic logic [BW-1:0] rq(input logic signed [33:0] x);
      logic signed [33:0] s;
      if (x < 34'sd0) return 17'd0;
      s = x >>> 8;
      if (s > 34'sd65535) return 17'd65535;
      return s[16:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: drive, check at negedge against the model, advance the model.
   task automatic cycle(input logic rst, input logic fs, input logic signed [33:0] val, input logic rdy);
      ent_t head;
      logic pop;
      logic wr;
      reset          = rst;
      bus.flag_store = fs;
      bus.max_number = val;
      bus.out_ready  = rdy;
      @(negedge clk);
      chk("out_valid", 32'(bus.out_valid), 32'(sbq.size() > 0));
      chk("level", 32'(bus.level), 32'(sbq.size()));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("map_done", 32'(bus.map_done), 32'(m_md));
      if (sbq.size() > 0) begin
         head = sbq[0];
         chk("out_data", 32'(bus.out_data), 32'(head.data));
         chk("out_last", 32'(bus.out_last), 32'(head.last));
      end
      if (bus.map_done === 1'b1) md_seen++;
      if (bus.out_valid === 1'b1 && rdy) begin
         pops++;
         if (bus.out_last === 1'b1) begin
            last_pops++;
            last_idx = pops;
         end
      end
      if (rst) begin
         sbq.delete();
         m_s1_v = 1'b0;
         m_elem = 0;
         m_md   = 1'b0;
         m_ovf  = 1'b0;
      end else begin
         pop = (sbq.size() > 0) && rdy;
         wr  = m_s1_v && (sbq.size() < DEPTH);
         if (m_s1_v && !wr) m_ovf = 1'b1;
         if (pop) void'(sbq.pop_front());
         if (wr) sbq.push_back(m_s1_e);
         m_md   = fs && (m_elem == MAP - 1);
         m_s1_v = fs;
         if (fs) begin
            m_s1_e.data = rq(val);
            m_s1_e.last = (m_elem == MAP - 1);
            m_elem      = (m_elem == MAP - 1) ? 0 : m_elem + 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset          = 1'b1;
      bus.flag_store = 1'b0;
      bus.max_number = 34'sd0;
      bus.out_ready  = 1'b0;
      m_s1_v = 1'b0; m_s1_e = '0; m_elem = 0; m_md = 1'b0; m_ovf = 1'b0;
      md_seen = 0; pops = 0; last_pops = 0; last_idx = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'd0);
      chk("rst_out_last", 32'(bus.out_last), 32'd0);
      chk("rst_map_done", 32'(bus.map_done), 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_level", 32'(bus.level), 32'd0);

      // 512 -> 2, visible two edges after the strobe.
      cycle(1'b0, 1'b1, 34'sd512, 1'b0);
      chk("lat_valid_early", 32'(bus.out_valid), 32'd0);
      cycle(1'b0, 1'b0, 34'sd0, 1'b0);
      chk("lat_valid", 32'(bus.out_valid), 32'd1);
      chk("lat_data", 32'(bus.out_data), 32'd2);
      chk("lat_last", 32'(bus.out_last), 32'd0);
      cycle(1'b0, 1'b0, 34'sd0, 1'b1);

      // Negative input clamps to zero.
      cycle(1'b0, 1'b1, -34'sd300, 1'b0);
      cycle(1'b0, 1'b0, 34'sd0, 1'b0);
      chk("neg_valid", 32'(bus.out_valid), 32'd1);
      chk("neg_data", 32'(bus.out_data), 32'd0);
      cycle(1'b0, 1'b0, 34'sd0, 1'b1);

      // 2^24 saturates.
      cycle(1'b0, 1'b1, 34'sd16777216, 1'b0);
      cycle(1'b0, 1'b0, 34'sd0, 1'b0);
      chk("sat_data", 32'(bus.out_data), 32'd65535);
      cycle(1'b0, 1'b0, 34'sd0, 1'b1);

      // One full map plus one element, streaming.
      cycle(1'b1, 1'b0, 34'sd0, 1'b0);
      md_seen = 0; pops = 0; last_pops = 0; last_idx = 0;
      for (int i = 0; i < 26; i++) cycle(1'b0, 1'b1, 34'(i * 512 + 100), 1'b1);
      repeat (4) cycle(1'b0, 1'b0, 34'sd0, 1'b1);
      chk("map_done_count", 32'(md_seen), 32'd1);
      chk("map_pops", 32'(pops), 32'd26);
      chk("map_last_count", 32'(last_pops), 32'd1);
      chk("map_last_index", 32'(last_idx), 32'd25);

      // Overflow: 18 strobes into 16 entries, then drain.
      cycle(1'b1, 1'b0, 34'sd0, 1'b0);
      for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1, 34'(i * 1000 + 300), 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 34'sd0, 1'b0);
      chk("ovf_level", 32'(bus.level), 32'd16);
      chk("ovf_flag", 32'(bus.overflow), 32'd1);
      pops = 0; last_pops = 0; md_seen = 0;
      repeat (17) cycle(1'b0, 1'b0, 34'sd0, 1'b1);
      chk("ovf_drain_pops", 32'(pops), 32'd16);
      chk("ovf_drain_level", 32'(bus.level), 32'd0);
      chk("ovf_sticky", 32'(bus.overflow), 32'd1);
      // Positions 18..24: the 7th strobe closes the map.
      for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 34'(i * 2048 + 7), 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 34'sd0, 1'b1);
      chk("pos_last_count", 32'(last_pops), 32'd1);
      chk("pos_map_done", 32'(md_seen), 32'd1);

      // Full buffer: strobe lands in the same cycle as a pop.
      cycle(1'b1, 1'b0, 34'sd0, 1'b0);
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 34'(i * 700 + 5), 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 34'sd0, 1'b0);
      chk("full_level", 32'(bus.level), 32'd16);
      chk("full_no_ovf", 32'(bus.overflow), 32'd0);
      cycle(1'b0, 1'b1, 34'sd99999, 1'b0);
      cycle(1'b0, 1'b0, 34'sd0, 1'b1);
      chk("fullpop_level", 32'(bus.level), 32'd15);
      chk("fullpop_ovf", 32'(bus.overflow), 32'd1);

      // Reset with 5 queued entries and a strobe in flight.
      cycle(1'b1, 1'b0, 34'sd0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 34'(i * 300 + 1000), 1'b0);
      cycle(1'b0, 1'b1, 34'sd4096, 1'b0);
      chk("pre_rst_level", 32'(bus.level), 32'd5);
      cycle(1'b1, 1'b1, 34'sd8192, 1'b0);
      chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_level", 32'(bus.level), 32'd0);
      repeat (4) cycle(1'b0, 1'b0, 34'sd0, 1'b1);
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("post_rst_level", 32'(bus.level), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
